// File: rtl/limit_counter.sv
// rtl/limit_counter.sv - loop counter with loadable limit and wrap/saturate/one-shot run modes
// Define LIMIT_COUNTER_CLAMP_EN to clamp count to a shrunken limit instead of zeroing it.
module limit_counter #(
   parameter int         WIDTH       = 32,
   parameter logic [WIDTH-1:0] RESET_LIMIT = {WIDTH{1'b1}}
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic             en,
   input  logic             load_limit,
   input  logic [WIDTH-1:0] limit_in,
   output logic [WIDTH-1:0] count,
   output logic [WIDTH-1:0] limit,
   output logic             count_start,
   output logic             count_end,
   output logic             busy,
   output logic             done,
   output logic             wrap
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;

   localparam logic [1:0] MODE_WRAP    = 2'b00;
   localparam logic [1:0] MODE_SAT     = 2'b01;
   localparam logic [1:0] MODE_ONESHOT = 2'b10;

   logic [1:0] state;
   logic [1:0] mode_q;
   logic       shrink;
   logic       at_limit;

   assign at_limit    = (count == limit);
   assign count_start = (count == '0);
   assign count_end   = at_limit;
   assign busy        = (state == ST_RUN);
   assign shrink      = (state == ST_RUN) && (limit_in < count);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         mode_q <= MODE_WRAP;
         count  <= '0;
         limit  <= RESET_LIMIT;
         done   <= 1'b0;
         wrap   <= 1'b0;
      end else begin
         done <= 1'b0;
         wrap <= 1'b0;
         if (clear) begin
            state <= ST_IDLE;
            count <= '0;
         end else if (start) begin
            state  <= ST_RUN;
            count  <= '0;
            mode_q <= mode;
         end else if (load_limit) begin
            limit <= limit_in;
            if (shrink) begin
`ifdef LIMIT_COUNTER_CLAMP_EN
               count <= limit_in;
`else
               count <= '0;
`endif
            end
         end else if (en && (state == ST_RUN)) begin
            if (!at_limit) begin
               count <= count + 1'b1;
            end else begin
               // Reserved mode 11 falls into the default WRAP arm.
               case (mode_q)
                  MODE_SAT: begin
                     done  <= 1'b1;
                     state <= ST_HOLD;
                  end
                  MODE_ONESHOT: begin
                     count <= '0;
                     done  <= 1'b1;
                     state <= ST_IDLE;
                  end
                  default: begin
                     count <= '0;
                     wrap  <= 1'b1;
                  end
               endcase
            end
         end
      end
   end

endmodule
